// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit for the EX stage; owns HI/LO and
// stalls dependent instructions while a 32-step operation is in flight.
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             rd_hilo,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  localparam logic [2:0]         OP_MTHI  = 3'd4;
  localparam logic [2:0]         OP_MTLO  = 3'd5;
  localparam logic [WIDTH-1:0]   ONE_W    = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W   = 1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state, w_state_next;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_dsr;
  logic [WIDTH-1:0]   r_rs_raw;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div, r_neg_res, r_neg_rem, r_div0;

  logic               w_accept, w_arith, w_signed;
  logic [WIDTH-1:0]   w_rs_abs, w_rt_abs;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH+1:0]   w_diff;
  logic [2*WIDTH-1:0] w_acc_step, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_accept = start & ~flush;
  assign w_arith  = w_accept & ~op[2];
  assign w_signed = ~op[0];
  assign w_rs_abs = (w_signed & rs_data[WIDTH-1]) ? (~rs_data + ONE_W) : rs_data;
  assign w_rt_abs = (w_signed & rt_data[WIDTH-1]) ? (~rt_data + ONE_W) : rt_data;

  // Multiply: conditional add into the upper half, then shift the whole accumulator right.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_dsr} : '0);

  // Divide: restoring step; upper half is the partial remainder, lower half shifts in quotient bits.
  assign w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_dsr};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (r_is_div) begin
      if (!w_diff[WIDTH+1]) w_acc_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else                  w_acc_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  assign w_prod = r_neg_res ? (~r_acc + ONE_2W) : r_acc;
  assign w_quo  = r_neg_res ? (~r_acc[WIDTH-1:0] + ONE_W) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + ONE_W) : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_arith) w_state_next = S_CALC;
      S_CALC:  if (flush) w_state_next = S_IDLE;
               else if (r_cnt == CNT_LAST) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc     <= '0;
      r_dsr     <= '0;
      r_rs_raw  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_arith) begin
            r_acc     <= {{WIDTH{1'b0}}, w_rs_abs};
            r_dsr     <= w_rt_abs;
            r_rs_raw  <= rs_data;
            r_cnt     <= '0;
            r_is_div  <= op[1];
            r_neg_res <= w_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            r_neg_rem <= w_signed & rs_data[WIDTH-1];
            r_div0    <= (rt_data == '0);
          end else if (w_accept && op == OP_MTHI) begin
            r_hi <= rs_data;
          end else if (w_accept && op == OP_MTLO) begin
            r_lo <= rs_data;
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_FIX: begin
          if (!flush) begin
            if (!r_is_div) begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end else if (r_div0) begin
              r_hi <= r_rs_raw;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = (r_state != S_IDLE);
  assign stall = busy & (start | rd_hilo);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: arithmetic results, latency, stall,
// MTHI/MTLO, flush, mid-operation reset and ignored opcodes.
module tb_ex_muldiv;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data, rt_data;
  logic             rd_hilo, flush;
  logic [WIDTH-1:0] hi, lo;
  logic             busy, stall;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_hi, m_lo;

  ex_muldiv #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .rd_hilo (rd_hilo),
    .flush   (flush),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issues one arithmetic op, counts busy cycles and confirms HI/LO hold until completion.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo);
    int n;
    logic held;
    n = 0;
    held = 1'b1;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    tick();
    start = 1'b0;
    while (busy && n < 100) begin
      n++;
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      tick();
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " held"}, 64'(held), 64'd1);
    m_hi = e_hi;
    m_lo = e_lo;
    check({tag, " hi"}, 64'(hi), 64'(e_hi));
    check({tag, " lo"}, 64'(lo), 64'(e_lo));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
    rd_hilo = 1'b0; flush = 1'b0;
    m_hi = '0; m_lo = '0;
    tick(); tick();
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    reset = 1'b1;
    tick();

    // Back-to-back ops: each new start follows the first idle cycle.
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",      3'd3, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("divu_zero", 3'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_op("div_zero_s",3'd2, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // Stall while busy with an MFHI/MFLO pending; low on the first idle cycle.
    begin
      logic stall_ok, busy_ok;
      stall_ok = 1'b1; busy_ok = 1'b1;
      start = 1'b1; op = 3'd0; rs_data = 32'd5; rt_data = 32'd6;
      #1;
      check("stall idle start", 64'(stall), 64'd0);
      tick();
      start = 1'b0; rd_hilo = 1'b1;
      #1;
      for (int k = 1; k <= 40; k++) begin
        if (stall !== (k <= 33)) stall_ok = 1'b0;
        if (busy  !== (k <= 33)) busy_ok  = 1'b0;
        tick();
      end
      rd_hilo = 1'b0;
      check("stall window", 64'(stall_ok), 64'd1);
      check("busy window", 64'(busy_ok), 64'd1);
      m_hi = 32'd0; m_lo = 32'd30;
      check("stall mult hi", 64'(hi), 64'(m_hi));
      check("stall mult lo", 64'(lo), 64'(m_lo));
    end

    // A start presented while busy is ignored and raises stall.
    start = 1'b1; op = 3'd3; rs_data = 32'd9; rt_data = 32'd2;
    tick();
    op = 3'd5; rs_data = 32'hDEAD_BEEF;
    #1;
    check("busy start stall", 64'(stall), 64'd1);
    for (int k = 0; k < 40 && busy; k++) tick();
    start = 1'b0;
    m_hi = 32'd1; m_lo = 32'd4;
    check("busy start ignored lo", 64'(lo), 64'(m_lo));
    tick();

    // MTLO / MTHI when idle.
    start = 1'b1; op = 3'd5; rs_data = 32'hA5A5_A5A5;
    #1;
    check("mtlo stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0;
    check("mtlo lo", 64'(lo), 64'hA5A5_A5A5);
    check("mtlo busy", 64'(busy), 64'd0);
    m_lo = 32'hA5A5_A5A5;
    start = 1'b1; op = 3'd4; rs_data = 32'h1111_1111;
    tick();
    start = 1'b0;
    m_hi = 32'h1111_1111;
    check("mthi hi", 64'(hi), 64'(m_hi));

    // Flush coincident with MTHI in IDLE discards it.
    start = 1'b1; flush = 1'b1; op = 3'd4; rs_data = 32'h2222_2222;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush idle mthi", 64'(hi), 64'(m_hi));

    // Undefined opcode does nothing.
    start = 1'b1; op = 3'd6; rs_data = 32'h3333_3333; rt_data = 32'd1;
    tick();
    start = 1'b0;
    check("op6 busy", 64'(busy), 64'd0);
    check("op6 hi", 64'(hi), 64'(m_hi));
    check("op6 lo", 64'(lo), 64'(m_lo));

    // Flush during CALC cancels the divide.
    start = 1'b1; op = 3'd2; rs_data = 32'd50; rt_data = 32'd5;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    check("flush pre busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    for (int k = 0; k < 40; k++) tick();
    check("flush hi", 64'(hi), 64'(m_hi));
    check("flush lo", 64'(lo), 64'(m_lo));

    // Flush landing on the FIX cycle suppresses the write.
    start = 1'b1; op = 3'd3; rs_data = 32'd77; rt_data = 32'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 32; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush fix busy", 64'(busy), 64'd0);
    check("flush fix lo", 64'(lo), 64'(m_lo));

    // Reset mid-operation.
    start = 1'b1; op = 3'd2; rs_data = 32'd50; rt_data = 32'd5;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    m_hi = '0; m_lo = '0;

    // Unit is usable again after the mid-op reset.
    run_op("post_reset", 3'd3, 32'd1000, 32'd33, 32'd10, 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
